// File: rtl/bit_serial_alu_seq.sv
// ---------------------------------------------------------------------------
// bit_serial_alu_seq
//
// Runs 8-bit operations through an external combinational 1-bit ALU slice.
// An operand pair and opcode are accepted over a valid/ready handshake. The
// slice is then driven LSB-first for 8 cycles, with carry/borrow chained
// through a register. The assembled result and flags are presented behind an
// output valid/ready handshake.
//
// Ports
//   clk, rst_n          rising-edge clock, synchronous active-low reset
//   in_valid/in_ready   request handshake (in_ready high only in IDLE)
//   op_a, op_b          8-bit operands
//   op_cin              carry/borrow into bit 0 (ADD/SUB only)
//   alu_sel             slice opcode: 000 AND, 001 OR, 010 XOR, 011 ADD,
//                       100 SUB, 101 PASS A, 110 PASS B, 111 NOT A
//   slice_a/b/cin/sel   drive the slice inputs (all zero outside RUN)
//   slice_result/cout   slice outputs
//   res_valid/res_ready result handshake
//   result, carry, zero assembled result, final carry/borrow, result==0
//   ovf                 signed overflow for ADD/SUB
//
// Configuration
//   BIT_SERIAL_ALU_SEQ_OVF_EN  when defined, ovf is computed and registered.
//                              When undefined, ovf is tied to 0.
// ---------------------------------------------------------------------------
module bit_serial_alu_seq (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] op_a,
  input  logic [7:0] op_b,
  input  logic       op_cin,
  input  logic [2:0] alu_sel,
  output logic       slice_a,
  output logic       slice_b,
  output logic       slice_cin,
  output logic [2:0] slice_sel,
  input  logic       slice_result,
  input  logic       slice_cout,
  output logic       res_valid,
  input  logic       res_ready,
  output logic [7:0] result,
  output logic       carry,
  output logic       zero,
  output logic       ovf
);

  localparam logic [2:0] SEL_ADD = 3'b011;
  localparam logic [2:0] SEL_SUB = 3'b100;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t     state;
  logic [7:0] a_sh;
  logic [7:0] b_sh;
  logic [6:0] res_sh;    // bits 0..6; bit 7 comes straight from the slice
  logic [2:0] op_q;
  logic       carry_q;   // carry/borrow entering the current bit
  logic [2:0] cnt;

  logic       op_arith;
  logic       sel_arith;
  logic [7:0] final_res;

  assign op_arith  = (op_q == SEL_ADD) || (op_q == SEL_SUB);
  assign sel_arith = (alu_sel == SEL_ADD) || (alu_sel == SEL_SUB);
  assign final_res = {slice_result, res_sh};

  assign in_ready = (state == IDLE);

  // The slice loop is combinational: registered operand LSBs and carry go
  // out, the slice answer comes back within the same cycle.
  // NOTE: every signal driven from always_comb gets a default first so that
  // no path leaves it unassigned and no latch is inferred.
  always_comb begin
    slice_a   = 1'b0;
    slice_b   = 1'b0;
    slice_cin = 1'b0;
    slice_sel = 3'b000;
    if (state == RUN) begin
      slice_a   = a_sh[0];
      slice_b   = b_sh[0];
      slice_cin = carry_q;
      slice_sel = op_q;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the values from before the edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      a_sh      <= 8'h00;
      b_sh      <= 8'h00;
      res_sh    <= 7'h00;
      op_q      <= 3'b000;
      carry_q   <= 1'b0;
      cnt       <= 3'd0;
      res_valid <= 1'b0;
      result    <= 8'h00;
      carry     <= 1'b0;
      zero      <= 1'b0;
`ifdef BIT_SERIAL_ALU_SEQ_OVF_EN
      ovf       <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_sh    <= op_a;
            b_sh    <= op_b;
            op_q    <= alu_sel;
            carry_q <= sel_arith ? op_cin : 1'b0;
            cnt     <= 3'd0;
            state   <= RUN;
          end
        end
        RUN: begin
          res_sh  <= {slice_result, res_sh[6:1]};
          a_sh    <= {1'b0, a_sh[7:1]};
          b_sh    <= {1'b0, b_sh[7:1]};
          // Logic/pass ops may report a Cout (NOT A does); keep it out.
          carry_q <= op_arith ? slice_cout : 1'b0;
          cnt     <= cnt + 3'd1;
          if (cnt == 3'd7) begin
            result    <= final_res;
            carry     <= op_arith ? slice_cout : 1'b0;
            zero      <= (final_res == 8'h00);
`ifdef BIT_SERIAL_ALU_SEQ_OVF_EN
            // carry_q is the carry/borrow entering bit 7 at this edge.
            ovf       <= op_arith ? (carry_q ^ slice_cout) : 1'b0;
`endif
            res_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifndef BIT_SERIAL_ALU_SEQ_OVF_EN
  assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_bit_serial_alu_seq.sv
// ---------------------------------------------------------------------------
// tb_bit_serial_alu_seq
//
// Bench for bit_serial_alu_seq. A behavioural 1-bit ALU slice closes the
// loop on the slice_* ports. Expected results come from a word-level model
// and are queued at request time, then popped when res_valid is seen.
// ---------------------------------------------------------------------------
module tb_bit_serial_alu_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] op_a;
  logic [7:0] op_b;
  logic       op_cin;
  logic [2:0] alu_sel;
  logic       slice_a;
  logic       slice_b;
  logic       slice_cin;
  logic [2:0] slice_sel;
  logic       slice_result;
  logic       slice_cout;
  logic       res_valid;
  logic       res_ready;
  logic [7:0] result;
  logic       carry;
  logic       zero;
  logic       ovf;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [7:0] r;
    logic       c;
    logic       z;
    logic       v;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  bit_serial_alu_seq dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .op_a         (op_a),
    .op_b         (op_b),
    .op_cin       (op_cin),
    .alu_sel      (alu_sel),
    .slice_a      (slice_a),
    .slice_b      (slice_b),
    .slice_cin    (slice_cin),
    .slice_sel    (slice_sel),
    .slice_result (slice_result),
    .slice_cout   (slice_cout),
    .res_valid    (res_valid),
    .res_ready    (res_ready),
    .result       (result),
    .carry        (carry),
    .zero         (zero),
    .ovf          (ovf)
  );

  // Behavioural 1-bit ALU slice. SUB Cout is the borrow (A-B-Cin < 0).
  always_comb begin
    slice_result = 1'b0;
    slice_cout   = 1'b0;
    case (slice_sel)
      3'b000: slice_result = slice_a & slice_b;
      3'b001: slice_result = slice_a | slice_b;
      3'b010: slice_result = slice_a ^ slice_b;
      3'b011: begin
        slice_result = slice_a ^ slice_b ^ slice_cin;
        slice_cout   = (slice_a & slice_b) | (slice_cin & (slice_a ^ slice_b));
      end
      3'b100: begin
        slice_result = slice_a ^ slice_b ^ slice_cin;
        slice_cout   = (~slice_a & slice_b) | (slice_cin & ~(slice_a ^ slice_b));
      end
      3'b101: begin slice_result = slice_a;  slice_cout = slice_a; end
      3'b110: begin slice_result = slice_b;  slice_cout = slice_b; end
      default: begin slice_result = ~slice_a; slice_cout = 1'b1; end
    endcase
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [7:0] a, input logic [7:0] b,
                                 input logic cin, input logic [2:0] sel);
    exp_t e;
    logic [8:0] w;
    e.c = 1'b0;
    e.v = 1'b0;
    case (sel)
      3'b000: e.r = a & b;
      3'b001: e.r = a | b;
      3'b010: e.r = a ^ b;
      3'b011: begin
        w   = {1'b0, a} + {1'b0, b} + {8'h00, cin};
        e.r = w[7:0];
        e.c = w[8];
        e.v = (a[7] == b[7]) && (e.r[7] != a[7]);
      end
      3'b100: begin
        e.r = a - b - {7'h00, cin};
        e.c = ({1'b0, a} < ({1'b0, b} + {8'h00, cin}));
        e.v = (a[7] != b[7]) && (e.r[7] != a[7]);
      end
      3'b101: e.r = a;
      3'b110: e.r = b;
      default: e.r = ~a;
    endcase
`ifndef BIT_SERIAL_ALU_SEQ_OVF_EN
    e.v = 1'b0;
`endif
    e.z = (e.r == 8'h00);
    return e;
  endfunction

  // Drive one request (called #1 after an edge, DUT in IDLE) and queue its
  // expected result. Returns after the accept edge plus #1.
  task automatic send(input string tag, input logic [7:0] a, input logic [7:0] b,
                      input logic cin, input logic [2:0] sel);
    op_a = a; op_b = b; op_cin = cin; alu_sel = sel;
    in_valid = 1'b1;
    check({tag, ".in_ready"}, in_ready, 1'b1);
    sb.push_back(model(a, b, cin, sel));
    @(posedge clk); #1;
    in_valid = 1'b0;
    check({tag, ".slice_sel"}, slice_sel, sel);
  endtask

  // Wait for res_valid (bounded), check latency and pop/compare the result.
  // Starts one edge after acceptance has already been counted (k=0 at #1).
  task automatic collect(input string tag, input bit check_lat);
    int n;
    exp_t e;
    n = 0;
    while (!res_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (check_lat) check({tag, ".latency"}, n, 8);
    check({tag, ".res_valid"}, res_valid, 1'b1);
    if (sb.size() == 0) begin
      check({tag, ".scoreboard_empty"}, 1, 0);
    end else begin
      e = sb.pop_front();
      check({tag, ".result"}, result, e.r);
      check({tag, ".carry"},  carry,  e.c);
      check({tag, ".zero"},   zero,   e.z);
      check({tag, ".ovf"},    ovf,    e.v);
    end
  endtask

  task automatic release_result(input string tag);
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    check({tag, ".res_valid_low"}, res_valid, 1'b0);
    check({tag, ".in_ready_back"}, in_ready, 1'b1);
  endtask

  task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input logic cin, input logic [2:0] sel);
    send(tag, a, b, cin, sel);
    collect(tag, 1'b1);
    release_result(tag);
  endtask

  initial begin
    logic [7:0] held_res;
    rst_n = 1'b0; in_valid = 1'b0; res_ready = 1'b0;
    op_a = 8'h00; op_b = 8'h00; op_cin = 1'b0; alu_sel = 3'b000;
    repeat (3) @(posedge clk);
    #1;
    // in_valid asserted during reset must be ignored.
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    rst_n = 1'b1;
    check("reset.in_ready",  in_ready,  1'b1);
    check("reset.res_valid", res_valid, 1'b0);
    check("reset.result",    result,    8'h00);
    check("reset.flags",     {carry, zero, ovf}, 3'b000);
    check("reset.slice",     {slice_a, slice_b, slice_cin, slice_sel}, 6'h00);

    run_op("add_3c_0f",  8'h3C, 8'h0F, 1'b0, 3'b011);
    run_op("add_ff_01",  8'hFF, 8'h01, 1'b0, 3'b011);
    run_op("add_7f_01",  8'h7F, 8'h01, 1'b0, 3'b011);
    run_op("add_cin",    8'h12, 8'h34, 1'b1, 3'b011);
    run_op("sub_10_01",  8'h10, 8'h01, 1'b0, 3'b100);
    run_op("sub_00_01",  8'h00, 8'h01, 1'b0, 3'b100);
    run_op("sub_80_01",  8'h80, 8'h01, 1'b0, 3'b100);
    run_op("not_a5",     8'hA5, 8'h00, 1'b1, 3'b111);
    run_op("xor_f0_3c",  8'hF0, 8'h3C, 1'b0, 3'b010);
    run_op("passb_81",   8'h00, 8'h81, 1'b1, 3'b110);
    run_op("passa_c3",   8'hC3, 8'h18, 1'b0, 3'b101);
    run_op("and_f0_3c",  8'hF0, 8'h3C, 1'b0, 3'b000);
    run_op("or_f0_0c",   8'hF0, 8'h0C, 1'b0, 3'b001);

    // Backpressure: hold DONE for 5 cycles with a competing request.
    send("bp_first", 8'h55, 8'h22, 1'b0, 3'b011);
    collect("bp_first", 1'b1);
    held_res = result;
    op_a = 8'h09; op_b = 8'h04; op_cin = 1'b0; alu_sel = 3'b100;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("bp.res_valid_hold", res_valid, 1'b1);
      check("bp.result_hold",    result,    held_res);
      check("bp.in_ready_low",   in_ready,  1'b0);
    end
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    check("bp.released", res_valid, 1'b0);
    check("bp.in_ready_after", in_ready, 1'b1);
    sb.push_back(model(8'h09, 8'h04, 1'b0, 3'b100));
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("bp.second_accepted", in_ready, 1'b0);
    collect("bp_second", 1'b1);
    release_result("bp_second");

    // Reset in the middle of RUN (k=4): operation discarded.
    op_a = 8'hFF; op_b = 8'hFF; op_cin = 1'b1; alu_sel = 3'b011;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("rst_mid.slice_sel_run", slice_sel, 3'b011);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("rst_mid.in_ready",  in_ready,  1'b1);
    check("rst_mid.res_valid", res_valid, 1'b0);
    check("rst_mid.result",    result,    8'h00);
    check("rst_mid.flags",     {carry, zero, ovf}, 3'b000);
    check("rst_mid.slice",     {slice_a, slice_b, slice_cin, slice_sel}, 6'h00);
    repeat (10) @(posedge clk);
    #1;
    check("rst_mid.no_result", res_valid, 1'b0);

    run_op("add_01_01", 8'h01, 8'h01, 1'b0, 3'b011);

    check("scoreboard.drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog timeout observed=running expected=finished");
    $fatal(1, "watchdog");
  end

endmodule
